// File: rtl/cfg_regbank_pkg.sv
// Shared types and helpers for the cfg_regbank configuration register bank.
package cfg_regbank_pkg;

  typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

  localparam int MAX_CH   = 256;
  localparam int MAX_W    = 64;
  localparam int MAX_BITS = MAX_CH * MAX_W;

  // Pulls register idx's reset value out of a zero-extended flat reset vector.
  function automatic logic [MAX_W-1:0] slice_reset(input logic [MAX_BITS-1:0] vals,
                                                    input int idx, input int width);
    logic [MAX_BITS-1:0] sh;
    logic [MAX_W-1:0]    mask;
    sh   = vals >> (idx * width);
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    return sh[MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/cfg_regbank_reg.sv
// Single configuration register with a parameterised asynchronous reset value.
module cfg_regbank_reg
  import cfg_regbank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_q <= RST_VAL;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cfg_regbank.sv
// Bank of N_CH configuration registers with valid/ready write port and flat readout.
// Define CFG_REGBANK_SHADOW_EN to stage writes in a shadow bank published by i_commit.
module cfg_regbank
  import cfg_regbank_pkg::*;
#(
  parameter int                      N_CH       = 4,
  parameter int                      WIDTH      = 8,
  parameter logic [N_CH*WIDTH-1:0]   RESET_VALS = '0,
  localparam int                     AW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic [N_CH*WIDTH-1:0] o_values,
  input  logic                  i_commit,
  output logic                  o_busy,
  output logic                  o_err,
  input  logic                  i_err_clr
);

`ifdef CFG_REGBANK_SHADOW_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  localparam logic [MAX_BITS-1:0] RV_EXT = MAX_BITS'(RESET_VALS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rdy_en;
  logic             r_err;
  logic             w_acc;
  logic             w_in_range;
  logic             w_commit_cyc;
  logic [WIDTH-1:0] w_live [N_CH];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state  <= IDLE;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  // Without a shadow bank there is nothing to publish, so the FSM never leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (SHADOW_EN && i_commit) w_state_nxt = COMMIT;
      COMMIT: w_state_nxt = IDLE;
    endcase
  end

  assign w_commit_cyc = (r_state == COMMIT);
  assign o_busy       = w_commit_cyc;
  assign o_wr_ready   = r_rdy_en && (r_state == IDLE);
  assign w_acc        = i_wr_valid && o_wr_ready;
  assign w_in_range   = int'(i_wr_addr) < N_CH;

  // A new error beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && !w_in_range) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [WIDTH-1:0] RV_I = WIDTH'(slice_reset(RV_EXT, i, WIDTH));
    logic w_we;

    assign w_we = w_acc && w_in_range && (int'(i_wr_addr) == i);

`ifdef CFG_REGBANK_SHADOW_EN
    logic [WIDTH-1:0] w_shadow;

    cfg_regbank_reg #(.WIDTH(WIDTH), .RST_VAL(RV_I)) u_shadow (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_we     (w_we),
      .i_d      (i_wr_data),
      .o_q      (w_shadow)
    );

    cfg_regbank_reg #(.WIDTH(WIDTH), .RST_VAL(RV_I)) u_live (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_we     (w_commit_cyc),
      .i_d      (w_shadow),
      .o_q      (w_live[i])
    );
`else
    cfg_regbank_reg #(.WIDTH(WIDTH), .RST_VAL(RV_I)) u_live (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_we     (w_we),
      .i_d      (i_wr_data),
      .o_q      (w_live[i])
    );
`endif

    assign o_values[i*WIDTH +: WIDTH] = w_live[i];
  end

  assign o_rd_data = (int'(i_rd_addr) < N_CH) ? w_live[i_rd_addr] : '0;

endmodule
